sramx_arbiter: RTL and testbench
================================

# sramx_arbiter

Shares a single SRAMx port between the instruction bus and the data bus so both can run against one unified on-chip memory. Each cycle it grants at most one requester, issues the access on the SRAMx port, and routes the returned read data and `data_ok` back to the owner after a fixed SRAM latency. It sits between the CPU's IBus/DBus outputs and the memory. It replaces per-bus SRAMx adapters when instruction and data memories are merged.

## Interface
- `LATENCY`, default 1: SRAM read latency in cycles; legal range 1..4; the same latency applies to writes.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `ireq`  in  `ibus_req_t`  instruction request: `valid`, `addr`.
- `iresp`  out  `ibus_resp_t`  `addr_ok`, `data_ok`, `data`.
- `dreq`  in  `dbus_req_t`  data request: `valid`, `addr`, `size`, `strobe`, `data`.
- `dresp`  out  `dbus_resp_t`  `addr_ok`, `data_ok`, `data`.
- `sreq`  out  `sramx_req_t`  shared port: `en`, `wen`, `addr`, `wdata`.
- `sresp`  in  `sramx_resp_t`  `rdata`, valid exactly `LATENCY` cycles after `en`.

## Operation
- **Handshake.** A requester holds `valid` and its fields stable until it sees `addr_ok`. A request is accepted in a cycle with `valid && addr_ok`. At most one request is accepted per cycle.
- **Arbitration.**
  - A 1-bit round-robin pointer `ptr` selects I or D. Reset value is D.
  - Only one requester valid: that requester is granted.
  - Both valid: the requester named by `ptr` is granted.
  - On every grant, `ptr` is set to the non-granted requester.
- **Grant outputs.** `iresp.addr_ok = grant_i` and `dresp.addr_ok = grant_d`. Both are combinational from the valids and `ptr`, and are never both 1.
- **Issue.**
  - `sreq.en = grant_i | grant_d`.
  - I grant: `addr = ireq.addr`, `wen = 0`, `wdata = 0`.
  - D grant: `addr = dreq.addr`, `wen = dreq.strobe`, `wdata = dreq.data`.
  - No grant: all `sreq` fields are 0.
- **Addresses.** Addresses are 4-byte aligned; bits [1:0] pass through unchanged. `dreq.size` is unused.
- **In-flight tracking.** A `LATENCY`-deep shift register of {valid, owner} tags. Stage 0 loads {`sreq.en`, owner} each cycle. All stages shift every cycle and never stall.
- **Response.**
  - Tag leaving the last stage with valid=1 pulses `data_ok` for one cycle on the owner bus only.
  - `iresp.data` and `dresp.data` are both driven with `sresp.rdata` at all times. The data is meaningful only while `data_ok` is asserted.
  - Writes also produce `data_ok`; the data value is don't-care.
- **Pipelining.** Up to `LATENCY` accesses are in flight. Requesters may issue a new request every cycle. Responses return in acceptance order.

## Timing
- Request accepted in cycle T → `sreq.en` in cycle T → owner `data_ok` = 1 in cycle T+`LATENCY`.
- Back-to-back grants I, D, I in cycles T, T+1, T+2 → `data_ok` on I, D, I in cycles T+L, T+L+1, T+L+2.
- Reset in the cycle after the rising edge where `reset` = 1:
  - all tag valids = 0, `ptr` = D;
  - `sreq.en` = 0, `iresp.data_ok` = 0, `dresp.data_ok` = 0;
  - `addr_ok` outputs follow the valids combinationally but are forced to 0 while `reset` = 1.
- Reset mid-operation: all in-flight tags are discarded. No `data_ok` appears for accesses issued before reset.
- Continuous contention: grants alternate strictly, so neither requester waits more than 1 cycle.
- A requester dropping `valid` without seeing `addr_ok` is a protocol violation. The bench asserts it never happens.

## Structure
- Owner tag enum (`OWNER_I`, `OWNER_D`) and the tag struct {valid, owner} go in the shared SRAMx header alongside `sramx_req_t`/`sramx_resp_t`.
- Sub-module `rr_arbiter2`:
  - inputs: `clk`, `reset`, `req[1:0]`;
  - output: one-hot `grant[1:0]`;
  - holds `ptr`.
- The tag pipeline and the muxing stay in `sramx_arbiter`.

## Test plan
- **Reset:** hold `reset` 3 cycles with both valids = 1 → `sreq.en` = 0, both `addr_ok` = 0, no `data_ok`. First grant after release goes to D.
- **I only, LATENCY=1:** `ireq` `addr` = 0x1000 at T, memory word 0xDEADBEEF → `sreq.en` = 1 with `addr` = 0x1000 and `wen` = 0 at T; `iresp.data_ok` = 1 with `data` = 0xDEADBEEF at T+1; `dresp.data_ok` = 0.
- **Contention:** both valid for 4 cycles → grants D, I, D, I; `data_ok` alternates D, I, D, I one cycle later.
- **D write then I read, same address:**
  - D write to 0x2000, `strobe` = 0xF, `data` = 0x12345678;
  - then I read of 0x2000;
  - → I read returns 0x12345678; `dresp.data_ok` comes one cycle before `iresp.data_ok`.
- **LATENCY=3 pipelining:** 5 consecutive D reads to 0x0, 0x4, ..., 0x10 → `data_ok` in cycles T+3..T+7, with data in address order.
- **Reset mid-flight, LATENCY=2:** grant I at T, assert `reset` at T+1 → no `iresp.data_ok` at T+2.

Source files
------------

// File: rtl/sramx_arbiter_pkg.sv
// Shared SRAMx types: bus request/response structs, the in-flight owner tag,
// and the requester indices used by the two-way arbiter.
package sramx_arbiter_pkg;

  localparam int REQ_I = 0;
  localparam int REQ_D = 1;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } owner_t;

  typedef struct packed {
    logic   valid;
    owner_t owner;
  } tag_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;

  typedef struct packed {
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
  } sramx_req_t;

  typedef struct packed {
    logic [31:0] rdata;
  } sramx_resp_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. ptr names the requester that wins a tie and
// always flips to the loser after a grant, so contention alternates strictly.
module rr_arbiter2
  import sramx_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  owner_t ptr_q;
  owner_t ptr_d;

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= OWNER_D;
    else       ptr_q <= ptr_d;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant[REQ_I])      ptr_d = OWNER_D;
    else if (grant[REQ_D]) ptr_d = OWNER_I;
  end

  // Grants are suppressed during reset so nothing is issued while tags clear.
  always_comb begin
    grant = '0;
    if (!reset) begin
      if (req[REQ_I] && (!req[REQ_D] || ptr_q == OWNER_I)) grant[REQ_I] = 1'b1;
      else if (req[REQ_D])                                  grant[REQ_D] = 1'b1;
    end
  end

endmodule

// File: rtl/sramx_arbiter.sv
// Shares one SRAMx port between IBus and DBus. Handshake: a request is taken in
// any cycle with valid && addr_ok; data_ok returns LATENCY cycles later, in order.
module sramx_arbiter
  import sramx_arbiter_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  ibus_req_t   ireq,
  output ibus_resp_t  iresp,
  input  dbus_req_t   dreq,
  output dbus_resp_t  dresp,
  output sramx_req_t  sreq,
  input  sramx_resp_t sresp
);

  logic [1:0] req;
  logic [1:0] grant;
  tag_t       tags [LATENCY];
  tag_t       tag_out;
  logic       unused_size;

  // Transfer size is implied by the strobe mask.
  assign unused_size = ^dreq.size;

  always_comb begin
    req        = '0;
    req[REQ_I] = ireq.valid;
    req[REQ_D] = dreq.valid;
  end

  rr_arbiter2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .grant (grant)
  );

  always_comb begin
    sreq = '0;
    if (grant[REQ_I]) begin
      sreq.en   = 1'b1;
      sreq.addr = ireq.addr;
    end else if (grant[REQ_D]) begin
      sreq.en    = 1'b1;
      sreq.wen   = dreq.strobe;
      sreq.addr  = dreq.addr;
      sreq.wdata = dreq.data;
    end
  end

  // Tag pipeline mirrors the SRAM latency; it never stalls, so order is preserved.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) tags[i] <= '0;
    end else begin
      tags[0].valid <= sreq.en;
      tags[0].owner <= grant[REQ_D] ? OWNER_D : OWNER_I;
      for (int i = 1; i < LATENCY; i++) tags[i] <= tags[i-1];
    end
  end

  assign tag_out = tags[LATENCY-1];

  always_comb begin
    iresp         = '0;
    iresp.addr_ok = grant[REQ_I];
    iresp.data_ok = tag_out.valid && (tag_out.owner == OWNER_I);
    iresp.data    = sresp.rdata;
    dresp         = '0;
    dresp.addr_ok = grant[REQ_D];
    dresp.data_ok = tag_out.valid && (tag_out.owner == OWNER_D);
    dresp.data    = sresp.rdata;
  end

endmodule

// File: tb/tb_sramx_arbiter.sv
// Bench for sramx_arbiter: one shared stimulus drives four instances (LATENCY 1..4),
// each with its own delayed SRAM read path, checked against an access-level model.
module tb_sramx_arbiter;
  import sramx_arbiter_pkg::*;

  localparam int NL = 4;
  localparam int W  = 66;  // {issue_cycle[31:0], owner_d, is_write, data[31:0]}

  logic        clk = 1'b0;
  logic        reset;
  ibus_req_t   ireq;
  dbus_req_t   dreq;
  ibus_resp_t  iresp_a [NL];
  dbus_resp_t  dresp_a [NL];
  sramx_req_t  sreq_a  [NL];
  sramx_resp_t sresp_a [NL];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NL; g++) begin : g_dut
    sramx_arbiter #(.LATENCY(g + 1)) dut (
      .clk   (clk),
      .reset (reset),
      .ireq  (ireq),
      .iresp (iresp_a[g]),
      .dreq  (dreq),
      .dresp (dresp_a[g]),
      .sreq  (sreq_a[g]),
      .sresp (sresp_a[g])
    );
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // reference model state
  logic [W-1:0] exp_q[$];
  int           head [NL];
  owner_t       turn;
  logic [31:0]  ref_mem [logic [31:0]];

  // SRAM environment state
  logic [31:0]  sram_mem [logic [31:0]];
  logic [31:0]  pipe [NL][NL];
  logic [31:0]  rd_now;

  // driver state
  logic [31:0]  i_todo[$];
  logic [67:0]  d_todo[$];  // {addr, strobe, data}
  logic         i_busy = 1'b0, d_busy = 1'b0;
  logic         i_acc = 1'b0, d_acc = 1'b0;
  int           rate = 100;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      if (bad <= 100)
        $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = data[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  task automatic drive();
    logic hold_i, hold_d;
    hold_i = ireq.valid && !i_acc;
    hold_d = dreq.valid && !d_acc;
    if (i_busy && i_acc) i_busy = 1'b0;
    if (d_busy && d_acc) d_busy = 1'b0;
    if (!i_busy && i_todo.size() != 0 && $urandom_range(99) < rate) begin
      ireq.addr = i_todo.pop_front();
      i_busy    = 1'b1;
    end
    if (!d_busy && d_todo.size() != 0 && $urandom_range(99) < rate) begin
      {dreq.addr, dreq.strobe, dreq.data} = d_todo.pop_front();
      dreq.size = 3'($urandom_range(2));
      d_busy    = 1'b1;
    end
    ireq.valid = i_busy;
    dreq.valid = d_busy;
    assert (!hold_i || ireq.valid) else $error("ireq valid dropped before addr_ok");
    assert (!hold_d || dreq.valid) else $error("dreq valid dropped before addr_ok");
  endtask

  // Runs mid-cycle: compare every instance with the model, then advance the model.
  task automatic sample();
    logic         gi, gd, ei, ed;
    logic [W-1:0] e;
    logic [31:0]  rv, a, ea, ewd;
    logic [3:0]   ewen;
    gi = 1'b0;
    gd = 1'b0;
    if (!reset) begin
      if (ireq.valid && dreq.valid) begin
        gi = (turn == OWNER_I);
        gd = !gi;
      end else begin
        gi = ireq.valid;
        gd = dreq.valid;
      end
    end
    ea   = gi ? ireq.addr : (gd ? dreq.addr : 32'h0);
    ewen = gd ? dreq.strobe : 4'h0;
    ewd  = gd ? dreq.data : 32'h0;
    for (int k = 0; k < NL; k++) begin
      check($sformatf("L%0d_i_addr_ok", k + 1), 64'(iresp_a[k].addr_ok), 64'(gi));
      check($sformatf("L%0d_d_addr_ok", k + 1), 64'(dresp_a[k].addr_ok), 64'(gd));
      check($sformatf("L%0d_en", k + 1), 64'(sreq_a[k].en), 64'(gi | gd));
      check($sformatf("L%0d_addr", k + 1), 64'(sreq_a[k].addr), 64'(ea));
      check($sformatf("L%0d_wen", k + 1), 64'(sreq_a[k].wen), 64'(ewen));
      check($sformatf("L%0d_wdata", k + 1), 64'(sreq_a[k].wdata), 64'(ewd));
      ei = 1'b0;
      ed = 1'b0;
      if (head[k] < exp_q.size()) begin
        e = exp_q[head[k]];
        if (int'(e[65:34]) + k + 1 == cyc) begin
          ei = !e[33];
          ed = e[33];
          if (!e[32]) begin
            if (e[33]) check($sformatf("L%0d_d_data", k + 1), 64'(dresp_a[k].data), 64'(e[31:0]));
            else       check($sformatf("L%0d_i_data", k + 1), 64'(iresp_a[k].data), 64'(e[31:0]));
          end
          head[k]++;
        end
      end
      check($sformatf("L%0d_i_data_ok", k + 1), 64'(iresp_a[k].data_ok), 64'(ei));
      check($sformatf("L%0d_d_data_ok", k + 1), 64'(dresp_a[k].data_ok), 64'(ed));
    end
    if (gi) begin
      rv = ref_rd(ireq.addr);
      exp_q.push_back({cyc[31:0], 1'b0, 1'b0, rv});
      turn = OWNER_D;
    end
    if (gd) begin
      rv = ref_rd(dreq.addr);
      exp_q.push_back({cyc[31:0], 1'b1, |dreq.strobe, rv});
      if (|dreq.strobe) ref_mem[dreq.addr] = merge(rv, dreq.data, dreq.strobe);
      turn = OWNER_I;
    end
    if (reset) begin
      for (int k = 0; k < NL; k++) head[k] = exp_q.size();
      turn = OWNER_D;
    end
    i_acc  = iresp_a[0].addr_ok;
    d_acc  = dresp_a[0].addr_ok;
    rd_now = 32'h0;
    if (sreq_a[0].en) begin
      a      = sreq_a[0].addr;
      rd_now = sram_mem.exists(a) ? sram_mem[a] : init_word(a);
      if (|sreq_a[0].wen) sram_mem[a] = merge(rd_now, sreq_a[0].wdata, sreq_a[0].wen);
    end
  endtask

  task automatic step();
    drive();
    @(negedge clk);
    sample();
    @(posedge clk);
    cyc++;
    for (int k = 0; k < NL; k++) begin
      for (int s = NL - 1; s > 0; s--) pipe[k][s] = pipe[k][s-1];
      pipe[k][0]       = rd_now;
      sresp_a[k].rdata = pipe[k][k];
    end
    #1;
  endtask

  task automatic drain(input int extra);
    int n;
    n = 0;
    while ((i_busy || d_busy || i_todo.size() != 0 || d_todo.size() != 0) && n < 300) begin
      step();
      n++;
    end
    check("drain_idle", 64'({i_busy, d_busy, i_todo.size() != 0, d_todo.size() != 0}), 64'h0);
    repeat (extra) step();
  endtask

  initial begin
    int n;
    reset = 1'b1;
    ireq  = '0;
    dreq  = '0;
    turn  = OWNER_D;
    for (int k = 0; k < NL; k++) begin
      head[k]    = 0;
      sresp_a[k] = '0;
      for (int s = 0; s < NL; s++) pipe[k][s] = 32'h0;
    end
    sram_mem[32'h1000] = 32'hDEAD_BEEF;
    ref_mem[32'h1000]  = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;

    // reset held with both requesters waiting; D must win first afterwards
    i_todo.push_back(32'h0000_0100);
    d_todo.push_back({32'h0000_0104, 4'h0, 32'h0});
    repeat (3) step();
    reset = 1'b0;
    drain(NL + 1);

    // I-only read of the preloaded word
    i_todo.push_back(32'h0000_1000);
    drain(NL + 1);

    // contention: both busy for four grants
    i_todo.push_back(32'h0000_0020);
    i_todo.push_back(32'h0000_0024);
    d_todo.push_back({32'h0000_0028, 4'h0, 32'h0});
    d_todo.push_back({32'h0000_002C, 4'h0, 32'h0});
    drain(NL + 1);

    // D write then I read of the same word (an I grant first makes D win the tie)
    i_todo.push_back(32'h0000_3000);
    drain(0);
    d_todo.push_back({32'h0000_2000, 4'hF, 32'h1234_5678});
    i_todo.push_back(32'h0000_2000);
    drain(NL + 1);

    // five back-to-back D reads
    for (int i = 0; i < 5; i++) d_todo.push_back({32'(i * 4), 4'h0, 32'h0});
    drain(NL + 1);

    // reset one cycle after an I grant
    i_todo.push_back(32'h0000_1000);
    n = 0;
    do begin
      step();
      n++;
    end while (!(i_busy && i_acc) && n < 50);
    check("mid_grant_seen", 64'(i_acc), 64'h1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    drain(NL + 1);

    // randomized traffic with occasional resets
    rate = 60;
    for (int it = 0; it < 600; it++) begin
      if (i_todo.size() < 2 && $urandom_range(99) < 50)
        i_todo.push_back(32'h4000 | (32'($urandom_range(15)) << 2));
      if (d_todo.size() < 2 && $urandom_range(99) < 50)
        d_todo.push_back({32'h4000 | (32'($urandom_range(15)) << 2),
                          4'($urandom_range(15)), 32'($urandom)});
      reset = ($urandom_range(99) < 2);
      step();
    end
    reset = 1'b0;
    rate  = 100;
    drain(NL + 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
